i2c_target: RTL and testbench

I2C target (slave) endpoint that answers a single 7-bit address on an externally driven bus and maps transfers onto an 8-bit-addressed byte register port. It is the bus-side counterpart of our I2C controller and is used both as an on-chip peripheral front end and as the loop-back target in controller regression. SCL and SDA are sampled in the `clk` domain; the block never drives SCL and drives SDA open-drain via an output-enable.

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_line_cond.sv | 50 +++++
 rtl/i2c_target.sv | 152 +++++++++++++++
 tb/tb_i2c_target.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states and bus bit encodings.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } tgt_state_t;

  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_line_cond.sv
// Pad-line conditioning: 2-flop synchronizer, optional 3-sample majority
// filter (I2C_TARGET_GLITCH_FILTER_EN), and edge detection.
module i2c_line_cond (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;
  logic       cond;
  logic       hist_q;

  // Reset to 1 so an idle (pulled-up) bus produces no edges out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], line_in};
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] tap_q;
  logic       filt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_q  <= 2'b11;
      filt_q <= 1'b1;
    end else begin
      tap_q  <= {tap_q[0], sync_q[1]};
      filt_q <= (sync_q[1] & tap_q[0]) | (sync_q[1] & tap_q[1]) | (tap_q[0] & tap_q[1]);
    end
  end

  assign cond = filt_q;
`else
  assign cond = sync_q[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= 1'b1;
    else        hist_q <= cond;
  end

  assign level = cond;
  assign rise  = cond & ~hist_q;
  assign fall  = ~cond & hist_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target answering DEV_ADDR, mapped onto an 8-bit-addressed register port.
// Optional input glitch filter: define I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic       wr_en,
  output logic [7:0] wr_data,
  input  logic [7:0] rd_data,
  output logic       busy
);

  tgt_state_t state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, reg_addr_d, wr_data_d, shift_in;
  logic       first_q, first_d, sda_oe_d, wr_en_d, busy_d;
  logic       scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;
  logic       start_evt, stop_evt;

  i2c_line_cond u_scl (.clk(clk), .rst_n(rst_n), .line_in(scl_in),
                       .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));
  i2c_line_cond u_sda (.clk(clk), .rst_n(rst_n), .line_in(sda_in),
                       .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));

  assign start_evt = scl_lvl & sda_fall;
  assign stop_evt  = scl_lvl & sda_rise;
  assign shift_in  = {shift_q[6:0], sda_lvl};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    first_d    = first_q;
    sda_oe_d   = sda_oe;
    reg_addr_d = wr_en ? reg_addr + 8'd1 : reg_addr;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data;
    busy_d     = busy;
    if (start_evt) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_evt) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            if (shift_in[7:1] == DEV_ADDR) begin
              state_d = ADDR_ACK;
              busy_d  = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        // First fall drives the ACK, second fall releases it and moves on.
        ADDR_ACK, WR_ACK: if (scl_fall) begin
          if (!sda_oe) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            if (state_q == ADDR_ACK && shift_q[0] == I2C_RW_READ) begin
              state_d   = RD_DATA;
              shift_d   = rd_data;
              sda_oe_d  = ~rd_data[7];
              bit_cnt_d = 4'd1;
            end else begin
              state_d = WR_DATA;
              if (state_q == ADDR_ACK) first_d = 1'b1;
            end
          end
        end
        WR_DATA: if (scl_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            state_d = WR_ACK;
            if (first_q) begin
              reg_addr_d = shift_in;
              first_d    = 1'b0;
            end else begin
              wr_en_d   = 1'b1;
              wr_data_d = shift_in;
            end
          end
        end
        // bit_cnt counts bits already presented on SDA.
        RD_DATA: if (scl_fall) begin
          if (bit_cnt_q == 4'd8) begin
            sda_oe_d   = 1'b0;
            reg_addr_d = reg_addr + 8'd1;
            state_d    = RD_ACK;
          end else begin
            sda_oe_d  = ~shift_q[6];
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        RD_ACK: begin
          if (scl_rise && sda_lvl == I2C_NACK) begin
            state_d = IGNORE;
          end else if (scl_fall) begin
            state_d   = RD_DATA;
            shift_d   = rd_data;
            sda_oe_d  = ~rd_data[7];
            bit_cnt_d = 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'd0;
      first_q   <= 1'b0;
      sda_oe    <= 1'b0;
      reg_addr  <= 8'd0;
      wr_en     <= 1'b0;
      wr_data   <= 8'd0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      first_q   <= first_d;
      sda_oe    <= sda_oe_d;
      reg_addr  <= reg_addr_d;
      wr_en     <= wr_en_d;
      wr_data   <= wr_data_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bench-side bus controller, register-file
// model and expected-write queue, with one per-cycle compare process.
module tb_i2c_target;

  localparam logic [6:0] DEV = 7'h50;
  localparam int H = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_ctl = 1'b1;
  logic       sda_ctl = 1'b1;
  logic       scl_in, sda_in, sda_oe, wr_en, busy;
  logic [7:0] reg_addr, wr_data, rd_data;

  logic [7:0]  mem [256];
  logic [15:0] exp_q [$];
  logic [7:0]  model_ptr = 8'd0;
  int vectors = 0;
  int miscompares = 0;
  logic prev_oe = 1'b0, prev_rst = 1'b0, prev_wr = 1'b0;

  assign scl_in  = scl_ctl;
  assign sda_in  = sda_ctl & ~sda_oe;
  assign rd_data = mem[reg_addr];

  i2c_target #(.DEV_ADDR(DEV)) dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in),
    .sda_oe(sda_oe), .reg_addr(reg_addr), .wr_en(wr_en), .wr_data(wr_data),
    .rd_data(rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Per-cycle checks: write strobes against the expected queue, strobe width,
  // and SDA only moving while SCL is low.
  always @(negedge clk) begin
    if (rst_n && prev_rst) begin
      if (sda_oe !== prev_oe) chk("sda_change_scl_low", {7'd0, scl_in}, 8'd0);
      if (wr_en === 1'b1) begin
        chk("wr_en_width", {7'd0, prev_wr}, 8'd0);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_wr: got addr %h data %h, expected no write", reg_addr, wr_data);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          chk("wr_addr", reg_addr, e[15:8]);
          chk("wr_data", wr_data, e[7:0]);
        end
        mem[reg_addr] = wr_data;
      end
    end
    prev_oe  = sda_oe;
    prev_rst = rst_n;
    prev_wr  = wr_en;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    cyc(2); sda_ctl = 1'b1;
    cyc(H); scl_ctl = 1'b1;
    cyc(H); sda_ctl = 1'b0;
    cyc(H); scl_ctl = 1'b0;
  endtask

  task automatic bus_stop();
    cyc(2); sda_ctl = 1'b0;
    cyc(H); scl_ctl = 1'b1;
    cyc(H); sda_ctl = 1'b1;
    cyc(H);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    cyc(2); sda_ctl = b;
    cyc(H - 2); scl_ctl = 1'b1;
    if (glitch) begin
      cyc(4); scl_ctl = 1'b0;
      cyc(1); scl_ctl = 1'b1;
      cyc(H - 5);
    end else begin
      cyc(H);
    end
    scl_ctl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit glitch, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i], glitch && i == 7);
    cyc(2); sda_ctl = 1'b1;
    cyc(H - 2); scl_ctl = 1'b1;
    cyc(H / 2); ack = sda_in;
    cyc(H / 2); scl_ctl = 1'b0;
  endtask

  task automatic recv_byte(input logic ack_bit, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      cyc(2); sda_ctl = 1'b1;
      cyc(H - 2); scl_ctl = 1'b1;
      cyc(H / 2); d[i] = sda_in;
      cyc(H / 2); scl_ctl = 1'b0;
    end
    send_bit(ack_bit, 1'b0);
  endtask

  task automatic wr_txn(input logic [7:0] ptr, input int n, input logic [7:0] d0,
                        input logic [7:0] d1, input bit push, input bit glitch);
    logic a;
    logic [7:0] dd;
    bus_start();
    send_byte({DEV, 1'b0}, 1'b0, a);
    chk("addr_ack", {7'd0, a}, 8'd0);
    chk("busy_active", {7'd0, busy}, 8'd1);
    send_byte(ptr, 1'b0, a);
    chk("ptr_ack", {7'd0, a}, 8'd0);
    for (int i = 0; i < n; i++) begin
      dd = (i == 0) ? d0 : d1;
      if (push) exp_q.push_back({ptr + 8'(i), dd});
      send_byte(dd, glitch && i == 0, a);
      if (!glitch) chk("data_ack", {7'd0, a}, 8'd0);
    end
    bus_stop();
    model_ptr = ptr + 8'(n);
    chk("reg_addr_after", reg_addr, model_ptr);
    chk("busy_after_stop", {7'd0, busy}, 8'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    logic [7:0] d, gd, gexp;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5C;

    cyc(3);
    chk("rst_sda_oe", {7'd0, sda_oe}, 8'd0);
    chk("rst_wr_en", {7'd0, wr_en}, 8'd0);
    chk("rst_wr_data", wr_data, 8'd0);
    chk("rst_reg_addr", reg_addr, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    rst_n = 1'b1;
    cyc(5);

    // Pointer 0x10, two data bytes; literal expectations pin the model.
    exp_q.push_back({8'h10, 8'hA5});
    exp_q.push_back({8'h11, 8'h3C});
    wr_txn(8'h10, 2, 8'hA5, 8'h3C, 1'b0, 1'b0);
    chk("final_ptr_lit", reg_addr, 8'h12);

    // Pointer write, repeated START, read two bytes.
    mem[8'h20] = 8'h5A;
    mem[8'h21] = 8'hC3;
    bus_start();
    send_byte({DEV, 1'b0}, 1'b0, a);
    chk("rd_addr_w_ack", {7'd0, a}, 8'd0);
    send_byte(8'h20, 1'b0, a);
    chk("rd_ptr_ack", {7'd0, a}, 8'd0);
    bus_start();
    send_byte({DEV, 1'b1}, 1'b0, a);
    chk("rd_addr_r_ack", {7'd0, a}, 8'd0);
    recv_byte(1'b0, d);
    chk("rd_byte0", d, 8'h5A);
    recv_byte(1'b1, d);
    chk("rd_byte1", d, 8'hC3);
    cyc(H);
    chk("rd_released", {7'd0, sda_oe}, 8'd0);
    bus_stop();
    model_ptr = 8'h22;
    chk("rd_ptr_after", reg_addr, model_ptr);

    // Address mismatch: no ACK, no busy, no writes.
    bus_start();
    send_byte({7'h51, 1'b0}, 1'b0, a);
    chk("mismatch_nack", {7'd0, a}, 8'd1);
    chk("mismatch_busy", {7'd0, busy}, 8'd0);
    send_byte(8'h99, 1'b0, a);
    chk("mismatch_data_nack", {7'd0, a}, 8'd1);
    bus_stop();
    chk("mismatch_ptr", reg_addr, model_ptr);

    // Pointer wrap 0xFF -> 0x00.
    wr_txn(8'hFF, 2, 8'h11, 8'h22, 1'b1, 1'b0);

    // Reset during bit 4 of a read byte whose bits are all 0.
    mem[8'h60] = 8'h00;
    bus_start();
    send_byte({DEV, 1'b0}, 1'b0, a);
    send_byte(8'h60, 1'b0, a);
    bus_start();
    send_byte({DEV, 1'b1}, 1'b0, a);
    for (int i = 0; i < 4; i++) begin
      cyc(2); sda_ctl = 1'b1;
      cyc(H - 2); scl_ctl = 1'b1;
      cyc(H); scl_ctl = 1'b0;
    end
    cyc(2); sda_ctl = 1'b1;
    cyc(H - 2); scl_ctl = 1'b1;
    cyc(H / 2);
    chk("pre_rst_driving", {7'd0, sda_oe}, 8'd1);
    rst_n = 1'b0;
    #2;
    chk("rst_mid_sda_oe", {7'd0, sda_oe}, 8'd0);
    chk("rst_mid_ptr", reg_addr, 8'd0);
    chk("rst_mid_busy", {7'd0, busy}, 8'd0);
    cyc(3);
    rst_n = 1'b1;
    model_ptr = 8'd0;
    cyc(2); scl_ctl = 1'b0;
    cyc(H);
    wr_txn(8'h40, 1, 8'h77, 8'h00, 1'b1, 1'b0);

    // SCL low glitch during the MSB of a data byte.
    gd = 8'hA5;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    gexp = gd;
`else
    gexp = {gd[7], gd[7:1]};
`endif
    exp_q.push_back({8'h30, gexp});
    wr_txn(8'h30, 1, gd, 8'h00, 1'b0, 1'b1);

    cyc(5);
    chk("exp_queue_empty", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
